// File: rtl/rgb_duty_ramp.sv
// RGB duty slew generator: accepts target triples over valid/ready and steps each
// channel's duty toward its target, only at PWM-period boundaries.
module rgb_duty_ramp #(
  parameter int unsigned PWM_INTERVAL = 1200,
  parameter int unsigned STEP_PERIODS = 4,
  parameter int unsigned STEP_SIZE    = 8,
  localparam int unsigned W           = $clog2(PWM_INTERVAL)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] target_r,
  input  logic [W-1:0] target_g,
  input  logic [W-1:0] target_b,
  input  logic         target_valid,
  output logic         target_ready,
  output logic [W-1:0] duty_r,
  output logic [W-1:0] duty_g,
  output logic [W-1:0] duty_b,
  output logic         ramp_busy,
  output logic         ramp_done,
  output logic         period_start
);

  localparam int unsigned SW       = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [W-1:0] DutyMax  = W'(PWM_INTERVAL - 1);
  localparam logic [W-1:0] StepAmt  = W'(STEP_SIZE);
  localparam logic [SW-1:0] StepLast = SW'(STEP_PERIODS - 1);

  typedef enum logic [0:0] {StIdle, StRamp} state_e;

  state_e        state_q, state_d;
  logic          live_q;
  logic [W-1:0]  period_q;
  logic [SW-1:0] step_q;
  logic [W-1:0]  tgt_r_q, tgt_g_q, tgt_b_q;
  logic [W-1:0]  tgt_r_d, tgt_g_d, tgt_b_d;
  logic [W-1:0]  duty_r_q, duty_g_q, duty_b_q;
  logic [W-1:0]  duty_r_d, duty_g_d, duty_b_d;
  logic          done_q, done_d;
  logic [W-1:0]  cl_r, cl_g, cl_b;
  logic          period_wrap, step_tick;

  function automatic logic [W-1:0] clamp(input logic [W-1:0] v);
    return (v > DutyMax) ? DutyMax : v;
  endfunction

  function automatic logic [W-1:0] step_toward(input logic [W-1:0] cur,
                                               input logic [W-1:0] tgt);
    logic [W-1:0] diff;
    diff = '0;
    if (cur < tgt) begin
      diff = tgt - cur;
      return (diff > StepAmt) ? cur + StepAmt : tgt;
    end else if (cur > tgt) begin
      diff = cur - tgt;
      return (diff > StepAmt) ? cur - StepAmt : tgt;
    end
    return cur;
  endfunction

  assign cl_r = clamp(target_r);
  assign cl_g = clamp(target_g);
  assign cl_b = clamp(target_b);

  assign period_wrap = (period_q == DutyMax);
  assign step_tick   = live_q && period_wrap && (step_q == StepLast);

  // live_q holds the counters and handshake off until the first cycle out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      live_q   <= 1'b0;
      period_q <= '0;
      step_q   <= '0;
      tgt_r_q  <= '0;
      tgt_g_q  <= '0;
      tgt_b_q  <= '0;
      duty_r_q <= '0;
      duty_g_q <= '0;
      duty_b_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      live_q   <= 1'b1;
      tgt_r_q  <= tgt_r_d;
      tgt_g_q  <= tgt_g_d;
      tgt_b_q  <= tgt_b_d;
      duty_r_q <= duty_r_d;
      duty_g_q <= duty_g_d;
      duty_b_q <= duty_b_d;
      done_q   <= done_d;
      if (live_q) begin
        period_q <= period_wrap ? '0 : period_q + 1'b1;
        if (period_wrap) begin
          step_q <= (step_q == StepLast) ? '0 : step_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    tgt_r_d  = tgt_r_q;
    tgt_g_d  = tgt_g_q;
    tgt_b_d  = tgt_b_q;
    duty_r_d = duty_r_q;
    duty_g_d = duty_g_q;
    duty_b_d = duty_b_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (target_valid && target_ready) begin
          tgt_r_d = cl_r;
          tgt_g_d = cl_g;
          tgt_b_d = cl_b;
          if (cl_r == duty_r_q && cl_g == duty_g_q && cl_b == duty_b_q) begin
            done_d = 1'b1;
          end else begin
            state_d = StRamp;
          end
        end
      end
      StRamp: begin
        if (step_tick) begin
          duty_r_d = step_toward(duty_r_q, tgt_r_q);
          duty_g_d = step_toward(duty_g_q, tgt_g_q);
          duty_b_d = step_toward(duty_b_q, tgt_b_q);
          if (duty_r_d == tgt_r_q && duty_g_d == tgt_g_q && duty_b_d == tgt_b_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign target_ready = live_q && (state_q == StIdle);
  assign ramp_busy    = (state_q == StRamp);
  assign ramp_done    = done_q;
  assign period_start = live_q && (period_q == '0);
  assign duty_r       = duty_r_q;
  assign duty_g       = duty_g_q;
  assign duty_b       = duty_b_q;

endmodule
